led_scan_driver: RTL and testbench

//  Multi-digit, time-multiplexed 7-segment display driver. Latches an N-digit
//  BCD/hex word, scans one common-anode digit per slot, decodes active-low

---
 rtl/led_pkg.sv | 69 ++++++
 rtl/led_seg_lut.sv | 22 ++
 rtl/led_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_led_scan_driver.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the 7-segment scan driver: the active-low segment
//   code type, the dark/dash patterns, the glyph set 0..F and the nibble to
//   segment decode function used by led_seg_lut.
//
//   Segment codes are ordered {g,f,e,d,c,b,a} and are active-low: a 0 bit
//   lights that segment.
// -----------------------------------------------------------------------------
package led_pkg;

  typedef logic [6:0] seg_t;

  // One registered output slot: segment bus plus decimal point, both active-low.
  typedef struct packed {
    seg_t seg;
    logic dp_n;
  } seg_out_t;

  localparam seg_t SEG_DARK = 7'h7F;
  localparam seg_t SEG_DASH = 7'b0111111;

  localparam seg_t GLYPH_0 = 7'b1000000;
  localparam seg_t GLYPH_1 = 7'b1111001;
  localparam seg_t GLYPH_2 = 7'b0100100;
  localparam seg_t GLYPH_3 = 7'b0110000;
  localparam seg_t GLYPH_4 = 7'b0011001;
  localparam seg_t GLYPH_5 = 7'b0010010;
  localparam seg_t GLYPH_6 = 7'b0000010;
  localparam seg_t GLYPH_7 = 7'b1111000;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0010000;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b0000011;
  localparam seg_t GLYPH_C = 7'b1000110;
  localparam seg_t GLYPH_D = 7'b0100001;
  localparam seg_t GLYPH_E = 7'b0000110;
  localparam seg_t GLYPH_F = 7'b0001110;

  localparam seg_out_t SLOT_OFF = '{seg: SEG_DARK, dp_n: 1'b1};

  // Decode one nibble. Codes above 9 render as a dash unless hex_mode is set.
  function automatic seg_t seg_decode(input logic [3:0] nibble,
                                      input logic       hex_mode);
    seg_t result;
    result = SEG_DASH;
    case (nibble)
      4'h0: result = GLYPH_0;
      4'h1: result = GLYPH_1;
      4'h2: result = GLYPH_2;
      4'h3: result = GLYPH_3;
      4'h4: result = GLYPH_4;
      4'h5: result = GLYPH_5;
      4'h6: result = GLYPH_6;
      4'h7: result = GLYPH_7;
      4'h8: result = GLYPH_8;
      4'h9: result = GLYPH_9;
      4'hA: result = hex_mode ? GLYPH_A : SEG_DASH;
      4'hB: result = hex_mode ? GLYPH_B : SEG_DASH;
      4'hC: result = hex_mode ? GLYPH_C : SEG_DASH;
      4'hD: result = hex_mode ? GLYPH_D : SEG_DASH;
      4'hE: result = hex_mode ? GLYPH_E : SEG_DASH;
      4'hF: result = hex_mode ? GLYPH_F : SEG_DASH;
      default: result = SEG_DASH;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/led_seg_lut.sv
// -----------------------------------------------------------------------------
// led_seg_lut
//   Purely combinational nibble -> active-low 7-segment lookup.
//
//   Parameters
//     HEX_MODE  0: codes 10..15 render as a dash; 1: render as A,b,C,d,E,F
//   Ports
//     nibble_i  in   4   digit value to display
//     seg_o     out  7   {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module led_seg_lut
  import led_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i, HEX_MODE);

endmodule

// File: rtl/led_scan_driver.sv
// -----------------------------------------------------------------------------
// led_scan_driver
//   Time-multiplexed N-digit common-anode 7-segment driver. A shadow register
//   holds the displayed word; one digit is enabled per scan slot, with a short
//   all-off guard at the start of every slot so the shared segment bus can
//   settle before the next anode is switched on (anti-ghosting).
//
//   Parameters
//     N_DIGITS  digits driven (1..8); digit 0 is least significant
//     SCAN_DIV  clock cycles per digit slot, must exceed GUARD
//     GUARD     cycles at slot start with every digit off (>= 0)
//     HEX_MODE  0: codes 10..15 as dash; 1: as A,b,C,d,E,F
//
//   Ports
//     CLK          in   1             rising-edge clock
//     RST_N        in   1             synchronous reset, active-low
//     EN           in   1             1: show data; 0: dash on every digit
//     LOAD         in   1             capture DATA/DP into the shadow register
//     DATA         in   4*N_DIGITS    nibble i = value of digit i
//     DP           in   N_DIGITS      bit i = decimal point of digit i (1 = lit)
//     LZ_SUPPRESS  in   1             1: leading zeros dark (digit 0 never)
//     SEG          out  7             {g,f,e,d,c,b,a}, active-low, registered
//     SEG_DP       out  1             decimal point, active-low, registered
//     DIG_SEL      out  N_DIGITS      digit enable, active-low one-cold
//     FRAME_DONE   out  1             one-cycle pulse after the last slot ends
//
//   All outputs are registered from the current scan position and shadow
//   contents, so they trail the counters by one clock.
// -----------------------------------------------------------------------------
module led_scan_driver
  import led_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2,
  parameter int HEX_MODE = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    LOAD,
  input  logic [4*N_DIGITS-1:0]   DATA,
  input  logic [N_DIGITS-1:0]     DP,
  input  logic                    LZ_SUPPRESS,
  output logic [6:0]              SEG,
  output logic                    SEG_DP,
  output logic [N_DIGITS-1:0]     DIG_SEL,
  output logic                    FRAME_DONE
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]           cnt_q,        cnt_d;
  logic [IW-1:0]           idx_q,        idx_d;
  logic [4*N_DIGITS-1:0]   data_q,       data_d;
  logic [N_DIGITS-1:0]     dp_q,         dp_d;
  seg_out_t                out_q,        out_d;
  logic [N_DIGITS-1:0]     dig_sel_q,    dig_sel_d;
  logic                    frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------------
  logic slot_end;
  logic frame_end;
  logic in_guard;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned; otherwise synthesis infers a latch.
    slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(N_DIGITS - 1));
    in_guard  = (int'(cnt_q) < GUARD);

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow register: LOAD held high makes it transparent with one clock delay.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d = LOAD ? DATA : data_q;
    dp_d   = LOAD ? DP   : dp_q;
  end

  // ---------------------------------------------------------------------------
  // Current-digit selection and leading-zero mask.
  // upper_blank walks down from the most significant digit and stays set only
  // while every digit seen so far has a zero nibble and an unlit DP, so a lit
  // DP ends suppression at that digit and everything below it.
  // ---------------------------------------------------------------------------
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz_dark;
  logic                upper_blank;
  logic [N_DIGITS-1:0] dig_on;

  always_comb begin
    cur_nib     = '0;
    cur_dp      = 1'b0;
    cur_lz_dark = 1'b0;
    upper_blank = 1'b1;
    dig_on      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_blank = upper_blank && (data_q[4*i +: 4] == 4'h0) && !dp_q[i];
      if (idx_q == IW'(i)) begin
        cur_nib     = data_q[4*i +: 4];
        cur_dp      = dp_q[i];
        // Digit 0 is never suppressed so an all-zero word still shows "0".
        cur_lz_dark = upper_blank && (i != 0);
        dig_on[i]   = 1'b1;
      end
    end
  end

  seg_t lut_seg;

  led_seg_lut #(
    .HEX_MODE (HEX_MODE != 0)
  ) u_lut (
    .nibble_i (cur_nib),
    .seg_o    (lut_seg)
  );

  // ---------------------------------------------------------------------------
  // Output selection, highest priority first:
  // guard blanking > EN low (dash) > leading-zero dark > decoded glyph.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d        = SLOT_OFF;
    dig_sel_d    = '1;
    frame_done_d = frame_end;
    if (!in_guard) begin
      dig_sel_d = ~dig_on;
      if (!EN) begin
        out_d.seg = SEG_DASH;
      end else if (LZ_SUPPRESS && cur_lz_dark) begin
        out_d.seg = SEG_DARK;
      end else begin
        out_d.seg  = lut_seg;
        out_d.dp_n = ~cur_dp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the shadow word is cleared on reset on purpose: a display that
      // shows undefined glyphs after power-up is visible to the user, so
      // this storage is part of the architectural reset state.
      data_q       <= '0;
      dp_q         <= '0;
      out_q        <= SLOT_OFF;
      dig_sel_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      out_q        <= out_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG        = out_q.seg;
  assign SEG_DP     = out_q.dp_n;
  assign DIG_SEL    = dig_sel_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_led_scan_driver
//   Drives a decimal-mode and a hex-mode instance of led_scan_driver
//   (4 digits, 8 cycles per slot, 2 guard cycles) with the same stimulus and
//   compares both against a cycle-count based reference model.
// -----------------------------------------------------------------------------
module tb_led_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] GLYPHS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        lz;

  logic [6:0]  seg,     seg_h;
  logic        seg_dp,  seg_dp_h;
  logic [3:0]  dig_sel, dig_sel_h;
  logic        frame_done, frame_done_h;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_scan_driver #(
    .N_DIGITS (N), .SCAN_DIV (DIV), .GUARD (GRD), .HEX_MODE (0)
  ) dut (
    .CLK (clk), .RST_N (rst_n), .EN (en), .LOAD (load), .DATA (data),
    .DP (dp), .LZ_SUPPRESS (lz), .SEG (seg), .SEG_DP (seg_dp),
    .DIG_SEL (dig_sel), .FRAME_DONE (frame_done)
  );

  led_scan_driver #(
    .N_DIGITS (N), .SCAN_DIV (DIV), .GUARD (GRD), .HEX_MODE (1)
  ) dut_hex (
    .CLK (clk), .RST_N (rst_n), .EN (en), .LOAD (load), .DATA (data),
    .DP (dp), .LZ_SUPPRESS (lz), .SEG (seg_h), .SEG_DP (seg_dp_h),
    .DIG_SEL (dig_sel_h), .FRAME_DONE (frame_done_h)
  );

  // ---------------------------------------------------------------------------
  // Reference model: the display is a pure function of the number of clocks
  // since reset (slot = t / DIV, phase = t % DIV) and the captured word.
  // Returns {seg, seg_dp, dig_sel}.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input int v, input bit hex);
    if (v > 9 && !hex) return 7'b0111111;
    return GLYPHS[v];
  endfunction

  function automatic logic [11:0] model_out(input int t, input logic [15:0] d,
                                            input logic [3:0] p, input logic en_v,
                                            input logic lz_v, input bit hex);
    int         phase;
    int         digit;
    logic [3:0] dsel;
    logic       dark;
    phase = t % DIV;
    digit = (t / DIV) % N;
    if (phase < GRD) return {7'h7F, 1'b1, 4'hF};
    dsel        = 4'hF;
    dsel[digit] = 1'b0;
    if (!en_v) return {7'b0111111, 1'b1, dsel};
    dark = lz_v && (digit > 0);
    for (int j = digit; j < N; j++) begin
      if (d[4*j +: 4] != 4'h0 || p[j]) dark = 1'b0;
    end
    if (dark) return {7'h7F, 1'b1, dsel};
    return {glyph(int'(d[4*digit +: 4]), hex), ~p[digit], dsel};
  endfunction

  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [11:0] m_exp;
  logic [11:0] m_exp_h;
  logic        m_fd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_data  <= '0;
      m_dp    <= '0;
      m_exp   <= {7'h7F, 1'b1, 4'hF};
      m_exp_h <= {7'h7F, 1'b1, 4'hF};
      m_fd    <= 1'b0;
    end else begin
      m_exp   <= model_out(m_t, m_data, m_dp, en, lz, 1'b0);
      m_exp_h <= model_out(m_t, m_data, m_dp, en, lz, 1'b1);
      m_fd    <= ((m_t % FRAME) == FRAME - 1);
      m_t     <= m_t + 1;
      if (load) begin
        m_data <= data;
        m_dp   <= dp;
      end
    end
  end

  // Observed / expected vectors: {seg, seg_dp, dig_sel, frame_done, hex seg}.
  function automatic logic [19:0] obs();
    return {seg, seg_dp, dig_sel, frame_done, seg_h};
  endfunction

  function automatic logic [19:0] expv();
    return {m_exp, m_fd, m_exp_h[11:5]};
  endfunction

  localparam logic [19:0] RESET_VEC = {7'h7F, 1'b1, 4'hF, 1'b0, 7'h7F};

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; load = 1'b0; data = '0; dp = '0; lz = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== RESET_VEC)
        $display("FAIL reset_state: got %b expected %b", obs(), RESET_VEC);
      else n_pass++;
    end
  endtask

  task automatic test_basic_1234();
    int guard_cnt = 0;
    int d0_cnt    = 0;
    int d3_cnt    = 0;
    int fd_cnt    = 0;
    rst_n = 1'b1; data = 16'h1234; load = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL basic_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
      if (dig_sel == 4'hF && seg == 7'h7F && seg_dp) guard_cnt++;
      if (dig_sel == 4'b1110 && seg == 7'b0011001) d0_cnt++;
      if (dig_sel == 4'b0111 && seg == 7'b1111001) d3_cnt++;
      if (frame_done) fd_cnt++;
      load = 1'b0;
    end
    n_checks++;
    if (guard_cnt !== N * GRD)
      $display("FAIL basic_guard_cycles: got %0d expected %0d", guard_cnt, N * GRD);
    else n_pass++;
    n_checks++;
    if (d0_cnt !== DIV - GRD)
      $display("FAIL basic_digit0_glyph4: got %0d expected %0d", d0_cnt, DIV - GRD);
    else n_pass++;
    n_checks++;
    if (d3_cnt !== DIV - GRD)
      $display("FAIL basic_digit3_glyph1: got %0d expected %0d", d3_cnt, DIV - GRD);
    else n_pass++;
    n_checks++;
    if (fd_cnt !== 1)
      $display("FAIL basic_frame_done: got %0d expected 1", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_leading_zero();
    int d3_dark = 0;
    int d2_dark = 0;
    int d1_7    = 0;
    int d0_0    = 0;
    int d2_dp   = 0;
    int d3_dk2  = 0;
    data = 16'h0070; dp = 4'b0000; lz = 1'b1; load = 1'b1;
    for (int c = 0; c < FRAME + 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL lz_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
      load = 1'b0;
      if (c > 0) begin
        if (dig_sel == 4'b0111 && seg == 7'h7F && seg_dp) d3_dark++;
        if (dig_sel == 4'b1011 && seg == 7'h7F && seg_dp) d2_dark++;
        if (dig_sel == 4'b1101 && seg == 7'b1111000) d1_7++;
        if (dig_sel == 4'b1110 && seg == 7'b1000000) d0_0++;
      end
    end
    n_checks++;
    if ({d3_dark, d2_dark, d1_7, d0_0} !== {4{DIV - GRD}})
      $display("FAIL lz_digits: got %0d %0d %0d %0d expected %0d each",
               d3_dark, d2_dark, d1_7, d0_0, DIV - GRD);
    else n_pass++;

    dp = 4'b0100; load = 1'b1;
    for (int c = 0; c < FRAME + 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL lz_dp_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
      load = 1'b0;
      if (c > 0) begin
        if (dig_sel == 4'b1011 && seg == 7'b1000000 && !seg_dp) d2_dp++;
        if (dig_sel == 4'b0111 && seg == 7'h7F && seg_dp) d3_dk2++;
      end
    end
    n_checks++;
    if (d2_dp !== DIV - GRD || d3_dk2 !== DIV - GRD)
      $display("FAIL lz_dp_stops: got %0d %0d expected %0d each",
               d2_dp, d3_dk2, DIV - GRD);
    else n_pass++;
    dp = 4'b0000; lz = 1'b0;
  endtask

  task automatic test_hex_codes();
    int hits = 0;
    data = 16'h000A; load = 1'b1;
    for (int c = 0; c < FRAME + 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL hex_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
      load = 1'b0;
      if (c > 0 && dig_sel == 4'b1110 && seg == 7'b0111111 && seg_h == 7'b0001000)
        hits++;
    end
    n_checks++;
    if (hits !== DIV - GRD)
      $display("FAIL hex_digit0_dash_vs_A: got %0d expected %0d", hits, DIV - GRD);
    else n_pass++;
    // Random words across all codes, both decode modes.
    for (int w = 0; w < 4; w++) begin
      data = 16'($urandom); dp = 4'($urandom); load = 1'b1;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        n_checks++;
        if (obs() !== expv())
          $display("FAIL hex_random t=%0d: got %b expected %b", m_t, obs(), expv());
        else n_pass++;
        load = 1'b0;
      end
    end
  endtask

  task automatic test_enable();
    int spins  = 0;
    int fd_cnt = 0;
    int last_fd = -1;
    int gap    = 0;
    logic [11:0] want;
    while ((m_t % FRAME) != DIV + 4 && spins < 2 * FRAME) begin
      @(negedge clk);
      spins++;
    end
    n_checks++;
    if ((m_t % FRAME) != DIV + 4)
      $display("FAIL en_align: got t=%0d expected slot 1 phase 4", m_t);
    else n_pass++;
    en = 1'b0;
    @(negedge clk);
    want = {7'b0111111, 1'b1, 4'b1101};
    n_checks++;
    if ({seg, seg_dp, dig_sel} !== want)
      $display("FAIL en_low_next_cycle: got %b expected %b", {seg, seg_dp, dig_sel}, want);
    else n_pass++;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL en_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
      if (frame_done) begin
        fd_cnt++;
        if (last_fd >= 0) gap = c - last_fd;
        last_fd = c;
      end
    end
    n_checks++;
    if (fd_cnt !== 2 || gap !== FRAME)
      $display("FAIL en_frame_done: got %0d pulses gap %0d expected 2 pulses gap %0d",
               fd_cnt, gap, FRAME);
    else n_pass++;
    en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int spins = 0;
    logic [19:0] lit0;
    data = 16'h9876; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while ((m_t % FRAME) != 2 * DIV + 3 && spins < 2 * FRAME) begin
      @(negedge clk);
      spins++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== RESET_VEC)
      $display("FAIL midreset_state: got %b expected %b", obs(), RESET_VEC);
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < GRD; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== RESET_VEC)
        $display("FAIL midreset_guard%0d: got %b expected %b", c, obs(), RESET_VEC);
      else n_pass++;
    end
    @(negedge clk);
    lit0 = {7'b1000000, 1'b1, 4'b1110, 1'b0, 7'b1000000};
    n_checks++;
    if (obs() !== lit0)
      $display("FAIL midreset_first_lit: got %b expected %b", obs(), lit0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // LOAD held high: shadow follows DATA with one clock delay.
    load = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      data = 16'($urandom); dp = 4'($urandom); lz = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL b2b_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 10 * FRAME; c++) begin
      load = ($urandom_range(3) == 0);
      // Bias toward zero-heavy words so leading-zero paths are exercised.
      data = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(255));
      dp   = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
      en   = ($urandom_range(9) != 0);
      lz   = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs() !== expv())
        $display("FAIL random_cycle t=%0d: got %b expected %b", m_t, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_1234();
    test_leading_zero();
    test_hex_codes();
    test_enable();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
